// File: rtl/dino_collision_arbiter_pkg.sv
// Shared widths and game state encodings for the dino collision arbiter.
package dino_collision_arbiter_pkg;

    localparam int SCORE_W = 16;
    localparam int COORD_W = 32;
    localparam int SIZE_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

endpackage

// File: rtl/dino_collision_arbiter_aabb_overlap.sv
// Combinational strict overlap test between a margin-trimmed box (a) and a plain box (b).
module aabb_overlap
    import dino_collision_arbiter_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [SIZE_W-1:0]  a_w,
    input  logic [SIZE_W-1:0]  a_h,
    input  logic [SIZE_W-1:0]  margin,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [SIZE_W-1:0]  b_w,
    input  logic [SIZE_W-1:0]  b_h,
    output logic               overlap
);

    localparam int SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] a_l, a_r, a_t, a_b;
    logic [SUM_W-1:0] b_l, b_r, b_t, b_b;
    logic             a_empty, b_empty;

    // One extra bit keeps edge sums near the top of the coordinate range from wrapping.
    always_comb begin
        a_empty = ({1'b0, a_w} <= {margin, 1'b0}) || ({1'b0, a_h} <= {margin, 1'b0});
        b_empty = (b_w == '0) || (b_h == '0);
        a_l = {1'b0, a_x} + SUM_W'(margin);
        a_r = {1'b0, a_x} + SUM_W'(a_w) - SUM_W'(margin);
        a_t = {1'b0, a_y} + SUM_W'(margin);
        a_b = {1'b0, a_y} + SUM_W'(a_h) - SUM_W'(margin);
        b_l = {1'b0, b_x};
        b_r = {1'b0, b_x} + SUM_W'(b_w);
        b_t = {1'b0, b_y};
        b_b = {1'b0, b_y} + SUM_W'(b_h);
        overlap = !a_empty && !b_empty &&
                  (a_l < b_r) && (b_l < a_r) &&
                  (a_t < b_b) && (b_t < a_b);
    end

endmodule

// File: rtl/dino_collision_arbiter.sv
// Game FSM: checks the dino against two obstacle slots each frame, tracks score and restarts.
module dino_collision_arbiter
    import dino_collision_arbiter_pkg::*;
#(
    parameter int MARGIN        = 4,
    parameter int HIT_FRAMES    = 2,
    parameter int SCORE_DIV     = 6,
    parameter int RESTART_DELAY = 30
) (
    input  logic               FrameClk,
    input  logic               rst,
    input  logic               jump,
    input  logic [COORD_W-1:0] Dino_X,
    input  logic [COORD_W-1:0] Dino_Y,
    input  logic [SIZE_W-1:0]  DinoWidth,
    input  logic [SIZE_W-1:0]  DinoHeight,
    input  logic [COORD_W-1:0] Obs0_X,
    input  logic [COORD_W-1:0] Obs0_Y,
    input  logic [SIZE_W-1:0]  Obs0_W,
    input  logic [SIZE_W-1:0]  Obs0_H,
    input  logic               Obs0_Valid,
    input  logic [COORD_W-1:0] Obs1_X,
    input  logic [COORD_W-1:0] Obs1_Y,
    input  logic [SIZE_W-1:0]  Obs1_W,
    input  logic [SIZE_W-1:0]  Obs1_H,
    input  logic               Obs1_Valid,
    output logic               isDead,
    output logic               gameRunning,
    output logic               restart,
    output logic [SCORE_W-1:0] score
);

    localparam int HIT_W   = $clog2(HIT_FRAMES + 1);
    localparam int DIV_W   = $clog2(SCORE_DIV + 1);
    localparam int DELAY_W = $clog2(RESTART_DELAY + 1);

    localparam logic [HIT_W-1:0]   HIT_MAX   = HIT_W'(HIT_FRAMES - 1);
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(SCORE_DIV - 1);
    localparam logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(RESTART_DELAY);

    game_state_t        state;
    logic               ov0, ov1, overlap, hit_q, start_run;
    logic [HIT_W-1:0]   hit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DELAY_W-1:0] delay_cnt;

    aabb_overlap u_ov0 (
        .a_x(Dino_X), .a_y(Dino_Y), .a_w(DinoWidth), .a_h(DinoHeight),
        .margin(SIZE_W'(MARGIN)),
        .b_x(Obs0_X), .b_y(Obs0_Y), .b_w(Obs0_W), .b_h(Obs0_H),
        .overlap(ov0)
    );

    aabb_overlap u_ov1 (
        .a_x(Dino_X), .a_y(Dino_Y), .a_w(DinoWidth), .a_h(DinoHeight),
        .margin(SIZE_W'(MARGIN)),
        .b_x(Obs1_X), .b_y(Obs1_Y), .b_w(Obs1_W), .b_h(Obs1_H),
        .overlap(ov1)
    );

    // A restart from DEAD only becomes possible once the hold-off counter has saturated.
    always_comb begin
        overlap   = (ov0 && Obs0_Valid) || (ov1 && Obs1_Valid);
        start_run = jump && ((state == IDLE) ||
                             ((state == DEAD) && (delay_cnt == DELAY_MAX)));
    end

    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hit_q       <= 1'b0;
            hit_cnt     <= '0;
            div_cnt     <= '0;
            delay_cnt   <= '0;
            isDead      <= 1'b0;
            gameRunning <= 1'b0;
            restart     <= 1'b0;
            score       <= '0;
        end else begin
            hit_q   <= overlap;
            restart <= 1'b0;
            if (start_run) begin
                state       <= RUN;
                restart     <= 1'b1;
                gameRunning <= 1'b1;
                isDead      <= 1'b0;
                score       <= '0;
                hit_cnt     <= '0;
                div_cnt     <= '0;
                delay_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    RUN: begin
                        // Death wins over a score tick landing on the same edge.
                        if (hit_q && (hit_cnt == HIT_MAX)) begin
                            state       <= DEAD;
                            isDead      <= 1'b1;
                            gameRunning <= 1'b0;
                            hit_cnt     <= '0;
                            delay_cnt   <= '0;
                        end else begin
                            hit_cnt <= hit_q ? hit_cnt + HIT_W'(1) : '0;
                            if (div_cnt == DIV_MAX) begin
                                div_cnt <= '0;
                                if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
                            end else begin
                                div_cnt <= div_cnt + DIV_W'(1);
                            end
                        end
                    end
                    DEAD: begin
                        if (delay_cnt != DELAY_MAX) delay_cnt <= delay_cnt + DELAY_W'(1);
                    end
                    default: begin
                        state       <= IDLE;
                        isDead      <= 1'b0;
                        gameRunning <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dino_collision_arbiter.sv
// Directed bench for dino_collision_arbiter: overlap vector table plus multi-frame sequences.
module tb_dino_collision_arbiter;

    logic        FrameClk = 1'b0;
    logic        rst, jump;
    logic [31:0] Dino_X, Dino_Y, Obs0_X, Obs0_Y, Obs1_X, Obs1_Y;
    logic [10:0] DinoWidth, DinoHeight, Obs0_W, Obs0_H, Obs1_W, Obs1_H;
    logic        Obs0_Valid, Obs1_Valid;
    logic        isDead, gameRunning, restart;
    logic [15:0] score;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] dx, dy;
        logic [10:0] dw, dh;
        logic [31:0] ox, oy;
        logic [10:0] ow, oh;
        logic        slot;
        logic        valid;
        logic        exp_dead;
    } vec_t;

    vec_t vecs[$];

    dino_collision_arbiter dut (
        .FrameClk(FrameClk), .rst(rst), .jump(jump),
        .Dino_X(Dino_X), .Dino_Y(Dino_Y), .DinoWidth(DinoWidth), .DinoHeight(DinoHeight),
        .Obs0_X(Obs0_X), .Obs0_Y(Obs0_Y), .Obs0_W(Obs0_W), .Obs0_H(Obs0_H), .Obs0_Valid(Obs0_Valid),
        .Obs1_X(Obs1_X), .Obs1_Y(Obs1_Y), .Obs1_W(Obs1_W), .Obs1_H(Obs1_H), .Obs1_Valid(Obs1_Valid),
        .isDead(isDead), .gameRunning(gameRunning), .restart(restart), .score(score)
    );

    always #5 FrameClk = ~FrameClk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge FrameClk);
        #1;
    endtask

    task automatic clear_obstacles();
        Obs0_X = 0; Obs0_Y = 0; Obs0_W = 0; Obs0_H = 0; Obs0_Valid = 0;
        Obs1_X = 0; Obs1_Y = 0; Obs1_W = 0; Obs1_H = 0; Obs1_Valid = 0;
    endtask

    task automatic set_dino(input logic [31:0] x, input logic [31:0] y,
                            input logic [10:0] w, input logic [10:0] h);
        Dino_X = x; Dino_Y = y; DinoWidth = w; DinoHeight = h;
    endtask

    task automatic set_obs0(input logic [31:0] x, input logic [31:0] y,
                            input logic [10:0] w, input logic [10:0] h, input logic v);
        Obs0_X = x; Obs0_Y = y; Obs0_W = w; Obs0_H = h; Obs0_Valid = v;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        jump = 1'b0;
        clear_obstacles();
        set_dino(50, 100, 44, 47);
        step();
        step();
        rst = 1'b0;
    endtask

    // Jump in IDLE: entry edge raises restart, the following RUN edge drops it.
    task automatic start_run();
        jump = 1'b1;
        step();
        check("start_restart", restart, 1);
        check("start_running", gameRunning, 1);
        check("start_score", score, 0);
        jump = 1'b0;
        step();
        check("start_restart_drop", restart, 0);
    endtask

    task automatic add_vec(input logic [31:0] dx, input logic [31:0] dy, input logic [10:0] dw,
                           input logic [10:0] dh, input logic [31:0] ox, input logic [31:0] oy,
                           input logic [10:0] ow, input logic [10:0] oh, input logic slot,
                           input logic valid, input logic exp_dead);
        vec_t v;
        v.dx = dx; v.dy = dy; v.dw = dw; v.dh = dh;
        v.ox = ox; v.oy = oy; v.ow = ow; v.oh = oh;
        v.slot = slot; v.valid = valid; v.exp_dead = exp_dead;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        jump = 1'b0;
        clear_obstacles();
        set_dino(50, 100, 44, 47);

        // Trimmed dino box for (50,100,44,47) is x[54,90) y[104,143).
        add_vec(50, 100, 44, 47, 80, 120, 20, 30, 0, 1, 1);
        add_vec(50, 100, 44, 47, 90, 120, 20, 30, 0, 1, 0);
        add_vec(50, 100, 44, 47, 89, 120, 20, 30, 0, 1, 1);
        add_vec(50, 100, 44, 47, 34, 120, 20, 30, 0, 1, 0);
        add_vec(50, 100, 44, 47, 35, 120, 20, 30, 0, 1, 1);
        add_vec(50, 100, 44, 47, 60, 143, 10, 10, 0, 1, 0);
        add_vec(50, 100, 44, 47, 60, 142, 10, 10, 0, 1, 1);
        add_vec(50, 100, 44, 47, 60, 94, 10, 10, 0, 1, 0);
        add_vec(50, 100, 44, 47, 60, 120, 0, 10, 0, 1, 0);
        add_vec(50, 100, 44, 47, 60, 120, 10, 10, 1, 0, 0);
        add_vec(50, 100, 44, 47, 60, 120, 10, 10, 1, 1, 1);
        add_vec(50, 100, 8, 47, 0, 0, 2047, 2047, 0, 1, 0);
        add_vec(50, 100, 9, 47, 0, 0, 2047, 2047, 0, 1, 1);
        add_vec(32'hFFFF_FFF0, 100, 44, 47, 32'hFFFF_FFFF, 120, 20, 30, 0, 1, 1);

        // Reset then idle for 10 frames.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_restart", restart, 0);
        end
        check("idle_running", gameRunning, 0);
        check("idle_dead", isDead, 0);
        check("idle_score", score, 0);

        // Start and score with no obstacles: 60 RUN frames give 10 points.
        start_run();
        for (int i = 2; i <= 59; i++) step();
        check("score_59", score, 9);
        step();
        check("score_60", score, 10);
        check("score_running", gameRunning, 1);

        // Table of overlap vectors, each held for HIT_FRAMES frames from a fresh run.
        for (int i = 0; i < vecs.size(); i++) begin
            reset_dut();
            set_dino(vecs[i].dx, vecs[i].dy, vecs[i].dw, vecs[i].dh);
            start_run();
            if (vecs[i].slot == 1'b0) begin
                Obs0_X = vecs[i].ox; Obs0_Y = vecs[i].oy; Obs0_W = vecs[i].ow;
                Obs0_H = vecs[i].oh; Obs0_Valid = vecs[i].valid;
            end else begin
                Obs1_X = vecs[i].ox; Obs1_Y = vecs[i].oy; Obs1_W = vecs[i].ow;
                Obs1_H = vecs[i].oh; Obs1_Valid = vecs[i].valid;
            end
            step();
            step();
            step();
            check($sformatf("vec%0d_dead", i), isDead, {31'd0, vecs[i].exp_dead});
        end

        // Death latency, frozen score, then the restart hold-off.
        reset_dut();
        start_run();
        for (int i = 2; i <= 12; i++) step();
        check("pre_death_score", score, 2);
        set_obs0(80, 120, 20, 30, 1);
        step();
        check("death_edge1", isDead, 0);
        step();
        check("death_edge2", isDead, 0);
        step();
        check("death_edge3", isDead, 1);
        check("death_running", gameRunning, 0);
        check("death_score", score, 2);
        for (int i = 0; i < 5; i++) step();
        check("frozen_score", score, 2);
        jump = 1'b1;
        step();
        jump = 1'b0;
        check("jump_f5_ignored", isDead, 1);
        for (int i = 6; i < 29; i++) step();
        jump = 1'b1;
        step();
        jump = 1'b0;
        check("jump_f29_ignored", isDead, 1);
        check("jump_f29_restart", restart, 0);
        jump = 1'b1;
        Obs0_Valid = 1'b0;
        step();
        check("restart_f30_pulse", restart, 1);
        check("restart_f30_running", gameRunning, 1);
        check("restart_f30_dead", isDead, 0);
        check("restart_f30_score", score, 0);

        // Jump held in RUN does nothing; held through DEAD restarts on the first eligible edge.
        Obs0_Valid = 1'b1;
        step();
        check("restart_pulse_len", restart, 0);
        step();
        step();
        check("held_death", isDead, 1);
        for (int i = 0; i < 30; i++) step();
        check("held_f30_dead", isDead, 1);
        Obs0_Valid = 1'b0;
        step();
        check("held_restart", restart, 1);
        check("held_running", gameRunning, 1);
        jump = 1'b0;

        // Single-frame overlaps separated by a clear frame never accumulate.
        reset_dut();
        start_run();
        set_obs0(80, 120, 20, 30, 1);
        step();
        Obs0_Valid = 1'b0;
        step();
        step();
        Obs0_Valid = 1'b1;
        step();
        Obs0_Valid = 1'b0;
        step();
        step();
        step();
        check("glitch_running", gameRunning, 1);
        check("glitch_dead", isDead, 0);

        // Mid-run asynchronous reset with score 37.
        reset_dut();
        start_run();
        for (int i = 2; i <= 222; i++) step();
        check("midrun_score", score, 37);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_score", score, 0);
        check("midrun_rst_running", gameRunning, 0);
        check("midrun_rst_dead", isDead, 0);
        check("midrun_rst_restart", restart, 0);
        step();
        rst = 1'b0;
        step();
        check("midrun_idle", gameRunning, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
